// File: rtl/display_scanner_pkg.sv
// Shared constants, scan state encoding and leading-zero mask helper for the
// multiplexed 7-segment display scanner.
package display_scanner_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned LZ_W       = DIGIT_W * MAX_DIGITS;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Bit i set when digit i must be lit: digit 0 always, higher digits only if
  // any nibble at or above them is non-zero.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [LZ_W-1:0] value,
    input int unsigned     digits
  );
    logic [MAX_DIGITS-1:0] m;
    logic                  seen;
    m    = '0;
    seen = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < int'(digits)) begin
        seen = seen | (value[i*DIGIT_W +: DIGIT_W] != '0);
        m[i] = seen | (i == 0);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/display_scanner_prescaler.sv
// Slot counter and digit-index counter with wrap; exposes next-cycle values so
// the top can register outputs aligned to the counter position.
module scan_prescaler #(
  parameter  int unsigned DIGITS   = 4,
  parameter  int unsigned PRESCALE = 1000,
  localparam int unsigned CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1,
  localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_nxt_c,
  output logic [IDX_W-1:0] o_idx_nxt_c,
  output logic             o_slot_end_c,
  output logic             o_last_c,
  output logic             o_frame_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_frame_tick;
  logic             w_slot_end;
  logic             w_idx_last;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_tick_nxt;

  always_comb begin
    w_slot_end = (r_cnt == CNT_W'(PRESCALE - 1));
    w_idx_last = (r_idx == IDX_W'(DIGITS - 1));
    w_cnt_nxt  = w_slot_end ? '0 : r_cnt + CNT_W'(1);
    w_idx_nxt  = r_idx;
    if (w_slot_end) begin
      w_idx_nxt = w_idx_last ? '0 : r_idx + IDX_W'(1);
    end
    w_tick_nxt = (w_idx_nxt == IDX_W'(DIGITS - 1)) &&
                 (w_cnt_nxt == CNT_W'(PRESCALE - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_frame_tick <= w_tick_nxt;
    end
  end

  assign o_cnt        = r_cnt;
  assign o_cnt_nxt_c  = w_cnt_nxt;
  assign o_idx_nxt_c  = w_idx_nxt;
  assign o_slot_end_c = w_slot_end;
  assign o_last_c     = w_slot_end & w_idx_last;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: rtl/display_scanner.sv
// Multiplexes a DIGITS-wide hex value onto a shared 7-segment bus with
// frame-synchronous value commit, per-slot dead time and leading-zero blanking.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned LZ_SUPPRESS  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] data,
  output logic [DIGIT_W-1:0]        nibble,
  output logic [DIGITS-1:0]         digit_en,
  output logic                      frame_tick
);

  localparam int unsigned DATA_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]                w_cnt;
  logic [CNT_W-1:0]                w_cnt_nxt;
  logic [IDX_W-1:0]                w_idx_nxt;
  logic                            w_slot_end;
  logic                            w_last;
  logic                            w_frame_tick;

  logic [DATA_W-1:0]               r_active;
  logic [DATA_W-1:0]               r_shadow;
  logic                            r_pending;
  logic [DATA_W-1:0]               w_active_nxt;
  logic [DIGITS-1:0][DIGIT_W-1:0]  w_act_digits;
  logic [DIGITS-1:0]               w_mask;

  scan_state_e                     r_state;
  scan_state_e                     w_state_nxt;
  logic [DIGIT_W-1:0]              r_nibble;
  logic [DIGITS-1:0]               r_digit_en;
  logic [DIGIT_W-1:0]              w_nibble_nxt;
  logic [DIGITS-1:0]               w_digit_en_nxt;

  scan_prescaler #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_cnt        (w_cnt),
    .o_cnt_nxt_c  (w_cnt_nxt),
    .o_idx_nxt_c  (w_idx_nxt),
    .o_slot_end_c (w_slot_end),
    .o_last_c     (w_last),
    .o_frame_tick (w_frame_tick)
  );

  // Value shown from the next cycle on; a load on the last frame cycle wins.
  always_comb begin
    w_active_nxt = r_active;
    if (w_last) begin
      if (load) begin
        w_active_nxt = data;
      end else if (r_pending) begin
        w_active_nxt = r_shadow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      if (load) begin
        r_shadow <= data;
      end
      if (w_last) begin
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BLANK:   if (w_cnt == CNT_W'(BLANK_CYCLES - 1)) w_state_nxt = SHOW;
      SHOW:    if (w_slot_end) w_state_nxt = BLANK;
      default: w_state_nxt = BLANK;
    endcase
  end

  // Next-cycle output values; nibble reloads only on entry to a slot's blank.
  always_comb begin
    w_act_digits   = w_active_nxt;
    w_mask         = (LZ_SUPPRESS != 0) ? DIGITS'(lz_mask(LZ_W'(w_active_nxt), DIGITS))
                                        : '1;
    w_nibble_nxt   = r_nibble;
    w_digit_en_nxt = '0;
    if (w_cnt_nxt == '0) begin
      w_nibble_nxt = w_act_digits[w_idx_nxt];
    end
    if (w_state_nxt == SHOW && w_mask[w_idx_nxt]) begin
      w_digit_en_nxt[w_idx_nxt] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nibble   <= '0;
      r_digit_en <= '0;
    end else begin
      r_nibble   <= w_nibble_nxt;
      r_digit_en <= w_digit_en_nxt;
    end
  end

  assign nibble     = r_nibble;
  assign digit_en   = r_digit_en;
  assign frame_tick = w_frame_tick;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: two instances (leading-zero suppression
// on and off) share stimulus and are compared cycle by cycle against a frame model.
module tb_display_scanner;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned PRE    = 8;
  localparam int unsigned BLK    = 2;
  localparam int unsigned FRAME  = DIGITS * PRE;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        load  = 1'b0;
  logic [15:0] data  = '0;
  logic [3:0]  nib_a, nib_b;
  logic [3:0]  en_a, en_b;
  logic        tick_a, tick_b;

  int errors = 0;
  int checks = 0;

  logic [3:0] prev_en;
  logic [3:0] prev_nib;
  int         zero_run;
  bit         seen_en;

  always #5 clk = ~clk;

  display_scanner #(
    .DIGITS(DIGITS), .PRESCALE(PRE), .BLANK_CYCLES(BLK), .LZ_SUPPRESS(1)
  ) u_dut_lz (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data),
    .nibble(nib_a), .digit_en(en_a), .frame_tick(tick_a)
  );

  display_scanner #(
    .DIGITS(DIGITS), .PRESCALE(PRE), .BLANK_CYCLES(BLK), .LZ_SUPPRESS(0)
  ) u_dut_nolz (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data),
    .nibble(nib_b), .digit_en(en_b), .frame_tick(tick_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_en(input logic [15:0] val, input int p, input bit lz);
    int          s;
    int          c;
    logic [15:0] hi;
    s  = p / int'(PRE);
    c  = p % int'(PRE);
    hi = val >> (4 * s);
    if (c < int'(BLK)) return 4'b0000;
    if (lz && s > 0 && hi == 16'h0) return 4'b0000;
    return 4'(1 << s);
  endfunction

  function automatic logic [3:0] exp_nib(input logic [15:0] val, input int p);
    logic [15:0] sh;
    sh = val >> (4 * (p / int'(PRE)));
    return sh[3:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_monitor();
    prev_en  = '0;
    prev_nib = '0;
    zero_run = 0;
    seen_en  = 1'b0;
  endtask

  // One full frame starting at frame position 0; optional loads at ld1/ld2.
  task automatic run_frame(input string name, input logic [15:0] val,
                           input int ld1, input logic [15:0] d1,
                           input int ld2, input logic [15:0] d2);
    for (int p = 0; p < int'(FRAME); p++) begin
      check($sformatf("%s p%0d en_lz", name, p),    32'(en_a),   32'(exp_en(val, p, 1'b1)));
      check($sformatf("%s p%0d nib_lz", name, p),   32'(nib_a),  32'(exp_nib(val, p)));
      check($sformatf("%s p%0d en_nolz", name, p),  32'(en_b),   32'(exp_en(val, p, 1'b0)));
      check($sformatf("%s p%0d nib_nolz", name, p), 32'(nib_b),  32'(exp_nib(val, p)));
      check($sformatf("%s p%0d tick_lz", name, p),  32'(tick_a), 32'(p == int'(FRAME) - 1));
      check($sformatf("%s p%0d tick_nolz", name, p),32'(tick_b), 32'(p == int'(FRAME) - 1));
      if (en_a != 4'b0000) begin
        if (prev_en == 4'b0000 && seen_en)
          check($sformatf("%s p%0d blank_gap", name, p), 32'(zero_run >= int'(BLK)), 32'd1);
        if (prev_en != 4'b0000) begin
          check($sformatf("%s p%0d en_hold", name, p),  32'(en_a),  32'(prev_en));
          check($sformatf("%s p%0d nib_hold", name, p), 32'(nib_a), 32'(prev_nib));
        end
        seen_en  = 1'b1;
        zero_run = 0;
      end else begin
        zero_run++;
      end
      prev_en  = en_a;
      prev_nib = nib_a;
      if (p == ld1 || p == ld2) begin
        load = 1'b1;
        data = (p == ld1) ? d1 : d2;
      end
      step();
      load = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_monitor();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst en_lz",    32'(en_a),   32'd0);
    check("rst nib_lz",   32'(nib_a),  32'd0);
    check("rst tick_lz",  32'(tick_a), 32'd0);
    check("rst en_nolz",  32'(en_b),   32'd0);
    check("rst nib_nolz", 32'(nib_b),  32'd0);
    check("rst tick_nolz",32'(tick_b), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;

    run_frame("f0_zero",  16'h0000, 10, 16'h1A3F, -1, 16'h0);
    run_frame("f1_1a3f",  16'h1A3F,  5, 16'h0040, -1, 16'h0);
    run_frame("f2_0040",  16'h0040, -1, 16'h0,    -1, 16'h0);
    run_frame("f3_0040",  16'h0040, 12, 16'h1111, 20, 16'h2222);
    run_frame("f4_2222",  16'h2222, 31, 16'h3333, -1, 16'h0);
    check("pending after tick load", 32'(u_dut_lz.r_pending), 32'd0);
    run_frame("f5_3333",  16'h3333,  3, 16'h8888, -1, 16'h0);
    for (int f = 0; f < 4; f++)
      run_frame($sformatf("f%0d_8888", 6 + f), 16'h8888, -1, 16'h0, -1, 16'h0);

    // Walk into the digit-2 show window and reset asynchronously mid-slot.
    for (int i = 0; i < 19; i++) step();
    check("pre_rst en_lz", 32'(en_a), 32'h4);
    rst_n = 1'b0;
    #1;
    check("async rst en_lz",    32'(en_a),   32'd0);
    check("async rst nib_lz",   32'(nib_a),  32'd0);
    check("async rst tick_lz",  32'(tick_a), 32'd0);
    check("async rst en_nolz",  32'(en_b),   32'd0);
    check("async rst nib_nolz", 32'(nib_b),  32'd0);
    check("async rst tick_nolz",32'(tick_b), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    reset_monitor();
    run_frame("post_rst", 16'h0000, -1, 16'h0, -1, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
